// File: rtl/z80_mem_arbiter.sv
// Arbitrates the single external memory port between the Z80 fetch (I) and data (D) sides.
// One transaction at a time: IDLE -> grant -> BUSY until M_Ready -> one-cycle DONE.
module z80_mem_arbiter #(
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 8,
  parameter int MAX_D_BURST = 4
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              flush,
  input  logic              I_MREQ,
  input  logic [ADDR_W-1:0] I_Addr,
  output logic              I_wait,
  output logic [DATA_W-1:0] I_Data,
  input  logic              D_MREQ,
  input  logic              D_WR,
  input  logic [ADDR_W-1:0] D_Addr,
  input  logic [DATA_W-1:0] D_WData,
  output logic              D_wait,
  output logic [DATA_W-1:0] D_RData,
  output logic              M_Req,
  output logic              M_WR,
  output logic [ADDR_W-1:0] M_Addr,
  output logic [DATA_W-1:0] M_WData,
  input  logic [DATA_W-1:0] M_RData,
  input  logic              M_Ready
);

  localparam int SW = $clog2(MAX_D_BURST + 1);
  localparam logic [SW-1:0] MAX_CNT = SW'(MAX_D_BURST);

  typedef enum logic [1:0] {IDLE, I_BUSY, D_BUSY, DONE} state_t;

  state_t            state_q;
  logic              mReq_q;
  logic              mWr_q;
  logic [ADDR_W-1:0] mAddr_q;
  logic [DATA_W-1:0] mWData_q;
  logic [DATA_W-1:0] iData_q;
  logic [DATA_W-1:0] dRData_q;
  logic [SW-1:0]     dStreak_q;
  logic              iDone_q;
  logic              dDone_q;
  logic              cancel_q;

  logic              grantD_d;
  logic              grantI_d;
  logic [SW-1:0]     dStreakInc_d;

  // D has priority unless it has already won MAX_D_BURST times in a row over a waiting I
  always_comb begin
    grantD_d     = D_MREQ && (!I_MREQ || (dStreak_q < MAX_CNT));
    grantI_d     = !grantD_d && I_MREQ && !flush;
    dStreakInc_d = (dStreak_q == MAX_CNT) ? dStreak_q : dStreak_q + 1'b1;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= IDLE;
      mReq_q    <= 1'b0;
      mWr_q     <= 1'b0;
      mAddr_q   <= '0;
      mWData_q  <= '0;
      iData_q   <= '0;
      dRData_q  <= '0;
      dStreak_q <= '0;
      iDone_q   <= 1'b0;
      dDone_q   <= 1'b0;
      cancel_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (!I_MREQ) begin
            dStreak_q <= '0;
          end
          if (grantD_d) begin
            mReq_q   <= 1'b1;
            mWr_q    <= D_WR;
            mAddr_q  <= D_Addr;
            mWData_q <= D_WData;
            state_q  <= D_BUSY;
            if (I_MREQ) begin
              dStreak_q <= dStreakInc_d;
            end
          end else if (grantI_d) begin
            mReq_q    <= 1'b1;
            mWr_q     <= 1'b0;
            mAddr_q   <= I_Addr;
            cancel_q  <= 1'b0;
            dStreak_q <= '0;
            state_q   <= I_BUSY;
          end
        end
        // A flush anywhere up to and including the M_Ready cycle drops the fetched byte
        I_BUSY: begin
          if (M_Ready) begin
            mReq_q  <= 1'b0;
            mWr_q   <= 1'b0;
            state_q <= DONE;
            if (!(cancel_q || flush)) begin
              iData_q <= M_RData;
              iDone_q <= 1'b1;
            end
          end else if (flush) begin
            cancel_q <= 1'b1;
          end
        end
        D_BUSY: begin
          if (M_Ready) begin
            mReq_q  <= 1'b0;
            mWr_q   <= 1'b0;
            dDone_q <= 1'b1;
            state_q <= DONE;
            if (!mWr_q) begin
              dRData_q <= M_RData;
            end
          end
        end
        DONE: begin
          iDone_q <= 1'b0;
          dDone_q <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign I_wait  = I_MREQ & ~iDone_q;
  assign D_wait  = D_MREQ & ~dDone_q;
  assign I_Data  = iData_q;
  assign D_RData = dRData_q;
  assign M_Req   = mReq_q;
  assign M_WR    = mWr_q;
  assign M_Addr  = mAddr_q;
  assign M_WData = mWData_q;

endmodule
